// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a small 4-bit ALU: one operation in flight,
// round-robin or fixed-priority grant, result held until the consumer takes it.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       req1_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_y,
  output logic       resp_id,
  output logic       resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        last_r;
  logic        grant_s;
  logic        accept_s;
  logic [3:0]  a_r;
  logic [3:0]  b_r;
  logic [3:0]  op_r;
  logic        id_r;
  logic [7:0]  resp_y_r;
  logic        resp_id_r;
  logic        resp_err_r;
  logic        resp_valid_r;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    logic [7:0] ax;
    logic [7:0] bx;
    ax = {4'h0, a};
    bx = {4'h0, b};
    case (op)
      4'd0:    alu_f = ax + bx;
      4'd1:    alu_f = ax - bx;
      4'd2:    alu_f = ax * bx;
      4'd3:    alu_f = {4'h0, ~a};
      4'd4:    alu_f = {4'h0, a & b};
      4'd5:    alu_f = {4'h0, a | b};
      4'd6:    alu_f = {4'h0, a ^ b};
      4'd7:    alu_f = {4'h0, ~(a & b)};
      4'd8:    alu_f = {4'h0, ~(a | b)};
      4'd9:    alu_f = {4'h0, ~(a ^ b)};
      default: alu_f = 8'h00;
    endcase
  endfunction

  function automatic logic op_err_f(input logic [3:0] op);
    return (op > 4'd9);
  endfunction

  // Grant selection: contention resolved by the last-grant pointer or by fixed priority.
  always_comb begin
    grant_s = 1'b0;
    if (RR_EN && req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // Ready is combinational so a request is accepted in the cycle it is presented.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      req0_ready = req0_valid && !grant_s;
      req1_ready = req1_valid &&  grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept_s = req0_ready | req1_ready;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, operand capture, pointer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_r       <= 1'b1;
      a_r          <= 4'h0;
      b_r          <= 4'h0;
      op_r         <= 4'h0;
      id_r         <= 1'b0;
      resp_y_r     <= 8'h00;
      resp_id_r    <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      resp_valid_r <= (next_state_s == RESP);
      if (accept_s) begin
        a_r    <= grant_s ? req1_a  : req0_a;
        b_r    <= grant_s ? req1_b  : req0_b;
        op_r   <= grant_s ? req1_op : req0_op;
        id_r   <= grant_s;
        last_r <= grant_s;
      end
      // Response fields only change on the EXEC->RESP edge, so they hold while stalled.
      if (state_r == EXEC) begin
        resp_y_r   <= alu_f(a_r, b_r, op_r);
        resp_id_r  <= id_r;
        resp_err_r <= op_err_f(op_r);
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_y     = resp_y_r;
  assign resp_id    = resp_id_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1, rr;
  logic [3:0]  a0, b0, op0, a1, b1, op1;
  logic [1:0]  rdy0, rdy1, vld, rid, rerr;
  logic [15:0] y;

  int checks = 0;
  int errors = 0;

  // model state per instance (0 = round-robin, 1 = fixed priority)
  int has [2];
  int age [2];
  int last[2];
  int pa  [2];
  int pb  [2];
  int pop [2];
  int pid [2];

  int gl_rr[$];
  int gl_fp[$];
  int ry_rr[$];
  int rid_rr[$];
  int rerr_rr[$];

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(rdy0[0]),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(rdy1[0]),
    .resp_valid(vld[0]), .resp_ready(rr), .resp_y(y[7:0]), .resp_id(rid[0]),
    .resp_err(rerr[0])
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(rdy0[1]),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(rdy1[1]),
    .resp_valid(vld[1]), .resp_ready(rr), .resp_y(y[15:8]), .resp_id(rid[1]),
    .resp_err(rerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_result(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      3: return 15 - a;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7: return 15 - (a & b);
      8: return 15 - (a | b);
      9: return 15 - (a ^ b);
      default: return 0;
    endcase
  endfunction

  // One clock cycle: compare both instances with the model, log, advance the model.
  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      string nm;
      int    win;
      int    was;
      int    ev;
      nm  = (m == 0) ? "rr" : "fp";
      win = -1;
      was = has[m];
      if (!rst && was == 0) begin
        if (v0 && v1)  win = (m == 0) ? ((last[m] == 0) ? 1 : 0) : 0;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        else           win = -1;
      end
      ev = (was != 0 && age[m] >= 2) ? 1 : 0;
      check_value({nm, "_ready0"}, 32'(rdy0[m]), 32'(win == 0));
      check_value({nm, "_ready1"}, 32'(rdy1[m]), 32'(win == 1));
      check_value({nm, "_resp_valid"}, 32'(vld[m]), 32'(ev));
      if (ev != 0) begin
        check_value({nm, "_resp_y"}, 32'(y[m*8 +: 8]), 32'(ref_result(pa[m], pb[m], pop[m])));
        check_value({nm, "_resp_id"}, 32'(rid[m]), 32'(pid[m]));
        check_value({nm, "_resp_err"}, 32'(rerr[m]), 32'(pop[m] > 9));
      end
      if (rdy0[m]) begin
        if (m == 0) gl_rr.push_back(0); else gl_fp.push_back(0);
      end
      if (rdy1[m]) begin
        if (m == 0) gl_rr.push_back(1); else gl_fp.push_back(1);
      end
      if (m == 0 && vld[0] && rr && !rst) begin
        ry_rr.push_back(int'(y[7:0]));
        rid_rr.push_back(int'(rid[0]));
        rerr_rr.push_back(int'(rerr[0]));
      end
      if (rst) begin
        has[m] = 0; age[m] = 0; last[m] = 1;
      end else begin
        if (was != 0 && age[m] >= 2 && rr) has[m] = 0;
        else if (was != 0 && age[m] < 2) age[m]++;
        if (win >= 0) begin
          has[m]  = 1;
          age[m]  = 1;
          last[m] = win;
          pid[m]  = win;
          pa[m]   = (win == 1) ? int'(a1)  : int'(a0);
          pb[m]   = (win == 1) ? int'(b1)  : int'(b0);
          pop[m]  = (win == 1) ? int'(op1) : int'(op0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    gl_rr.delete(); gl_fp.delete(); ry_rr.delete(); rid_rr.delete(); rerr_rr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ones;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    a0 = 4'h0; b0 = 4'h0; op0 = 4'h0; a1 = 4'h0; b1 = 4'h0; op1 = 4'h0;
    for (int m = 0; m < 2; m++) begin
      has[m] = 0; age[m] = 0; last[m] = 1; pa[m] = 0; pb[m] = 0; pop[m] = 0; pid[m] = 0;
    end
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;
    check_value("reset_valid", 32'(vld), 32'h0);
    check_value("reset_y", 32'(y), 32'h0);
    check_value("reset_id_err", 32'({rid, rerr}), 32'h0);

    // basic add from req0 with latency check
    clear_logs();
    v0 = 1'b1; a0 = 4'd7; b0 = 4'd9; op0 = 4'd0; rr = 1'b1;
    step();
    v0 = 1'b0;
    check_value("s1_grant_cnt", 32'(gl_rr.size()), 32'd1);
    check_value("s1_exec_valid", 32'(vld[0]), 32'd0);
    step();
    check_value("s1_resp_valid", 32'(vld[0]), 32'd1);
    check_value("s1_resp_y", 32'(y[7:0]), 32'h10);
    check_value("s1_resp_id_err", 32'({rid[0], rerr[0]}), 32'h0);
    repeat (2) step();

    // continuous contention: alternate under round-robin, req0 always under fixed priority
    do_reset();
    clear_logs();
    v0 = 1'b1; a0 = 4'd15; b0 = 4'd15; op0 = 4'd2;
    v1 = 1'b1; a1 = 4'd3;  b1 = 4'd4;  op1 = 4'd2;
    rr = 1'b1;
    repeat (16) step();
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) step();
    check_value("s2_rr_count", 32'(gl_rr.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gl_rr.size() && i < ry_rr.size(); i++) begin
      check_value("s2_rr_grant", 32'(gl_rr[i]), 32'(i % 2));
      check_value("s2_rr_y", 32'(ry_rr[i]), (i % 2 == 1) ? 32'h0C : 32'hE1);
      check_value("s2_rr_id", 32'(rid_rr[i]), 32'(i % 2));
    end
    ones = 0;
    foreach (gl_fp[i]) ones += gl_fp[i];
    check_value("s2_fp_count", 32'(gl_fp.size() >= 4), 32'd1);
    check_value("s2_fp_req1_grants", 32'(ones), 32'd0);

    // stalled response holds stable and blocks new grants
    do_reset();
    clear_logs();
    v1 = 1'b1; a1 = 4'd2; b1 = 4'd5; op1 = 4'd1; rr = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      check_value("s4_valid_hold", 32'(vld[0]), 32'd1);
      check_value("s4_y_hold", 32'(y[7:0]), 32'hFD);
      check_value("s4_no_regrant", 32'(gl_rr.size()), 32'd1);
      step();
    end
    v1 = 1'b0; rr = 1'b1;
    repeat (2) step();
    check_value("s4_handoff_y", 32'(ry_rr.size() > 0 ? ry_rr[0] : -1), 32'hFD);

    // invalid opcode and NOT
    clear_logs();
    v0 = 1'b1; a0 = 4'($urandom_range(15)); b0 = 4'($urandom_range(15)); op0 = 4'd12;
    step();
    v0 = 1'b0;
    repeat (3) step();
    v0 = 1'b1; a0 = 4'hA; b0 = 4'h3; op0 = 4'd3;
    step();
    v0 = 1'b0;
    repeat (3) step();
    check_value("s5_resp_cnt", 32'(ry_rr.size()), 32'd2);
    if (ry_rr.size() == 2) begin
      check_value("s5_bad_y", 32'(ry_rr[0]), 32'h00);
      check_value("s5_bad_err", 32'(rerr_rr[0]), 32'd1);
      check_value("s5_not_y", 32'(ry_rr[1]), 32'h05);
      check_value("s5_not_err", 32'(rerr_rr[1]), 32'd0);
    end

    // reset while a response is pending aborts it
    v0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = 4'd0; rr = 1'b0;
    step();
    v0 = 1'b0;
    step();
    check_value("s6_in_resp", 32'(vld), 32'h3);
    clear_logs();
    do_reset();
    check_value("s6_abort_valid", 32'(vld), 32'h0);
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    step();
    v0 = 1'b0; v1 = 1'b0;
    check_value("s6_first_rr", 32'(gl_rr.size() == 1 && gl_rr[0] == 0), 32'd1);
    check_value("s6_first_fp", 32'(gl_fp.size() == 1 && gl_fp[0] == 0), 32'd1);
    repeat (3) step();
    check_value("s6_no_stale_resp", 32'(ry_rr.size()), 32'd1);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(63) == 0);
      v0  = ($urandom_range(2) != 0);
      v1  = ($urandom_range(2) != 0);
      rr  = ($urandom_range(3) != 0);
      a0  = 4'($urandom_range(15)); b0 = 4'($urandom_range(15)); op0 = 4'($urandom_range(15));
      a1  = 4'($urandom_range(15)); b1 = 4'($urandom_range(15)); op1 = 4'($urandom_range(15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with req0 highest.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 opcode.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_a, req1_b, req1_op, req1_ready: same as REQ-005..REQ-008, for requester 1.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_y  output  8  result.
REQ-013 resp_id  output  1  requester that owns the result.
REQ-014 resp_err  output  1  opcode was outside 0..9.

Function
REQ-015 FSM states: IDLE, EXEC, RESP. One operation is in flight at most.
REQ-016 Handshakes:
- reqN_ready is 1 only in IDLE, only for the granted requester, and only when reqN_valid is 1.
- Acceptance is reqN_valid & reqN_ready.
- Both ready outputs are never 1 in the same cycle.
REQ-017 Arbitration when RR_EN=1:
- If both requesters are valid, the grant goes to the requester not granted last.
- If one is valid, the grant goes to it.
- The last-grant pointer updates only on acceptance.
REQ-018 Arbitration when RR_EN=0: req0 wins whenever both are valid.
REQ-019 IDLE->EXEC on acceptance; a_q, b_q, op_q and id_q are captured on that edge.
REQ-020 EXEC->RESP after exactly one cycle; resp_y, resp_id and resp_err are registered on that edge.
REQ-021 RESP->IDLE on resp_valid & resp_ready.
- resp_y, resp_id and resp_err hold stable while resp_valid=1 and resp_ready=0.
REQ-022 resp_valid = 1 exactly in RESP; first possible resp_valid is 2 cycles after the accept edge.
REQ-023 A new acceptance is possible no earlier than the cycle after response handoff, giving a throughput of 1 operation per 3 cycles minimum.
REQ-024 Opcode table. Operands are zero-extended to 8 bits and arithmetic results are truncated to 8 bits.
- 0 = a+b
- 1 = a-b (mod 256)
- 2 = a*b
- 3 = {4'h0, ~a}
- 4 = {4'h0, a&b}
- 5 = {4'h0, a|b}
- 6 = {4'h0, a^b}
- 7 = {4'h0, ~(a&b)}
- 8 = {4'h0, ~(a|b)}
- 9 = {4'h0, ~(a^b)}
REQ-025 Opcodes 10..15: resp_y = 8'h00 and resp_err = 1; otherwise resp_err = 0. An invalid opcode still completes a normal handshake.
REQ-026 Inputs on the request ports are ignored outside the accept cycle; only captured values affect the result.
REQ-027 A requester deasserting valid before acceptance loses no state, and the arbitration pointer is unchanged.

Reset
REQ-028 While rst=1 at a rising edge, all of the following take effect on that edge:
- state = IDLE;
- resp_valid = 0, resp_y = 8'h00, resp_id = 0, resp_err = 0;
- last-grant pointer = 1, so req0 wins the first contention;
- captured operand registers = 0.
REQ-029 Reset asserted in EXEC or RESP aborts the operation; no response is delivered for it.
REQ-030 req0_ready and req1_ready are 0 during any cycle in which rst=1.

Verification
REQ-031 Bench scenarios:
- Reset, then req0 {a=4'd7, b=4'd9, op=0}, resp_ready=1 -> req0_ready the same cycle; resp_valid 2 cycles later with resp_y=8'h10, resp_id=0, resp_err=0.
- req0 and req1 both valid continuously, RR_EN=1, op=2, req0 {15,15}, req1 {3,4} -> grants alternate 0,1,0,1; results 8'hE1 (id 0) and 8'h0C (id 1).
- Same stimulus as the previous scenario with RR_EN=0 -> req0 is granted every time and req1_ready stays 0.
- req1 {a=4'd2, b=4'd5, op=1}, resp_ready held 0 for 5 cycles -> resp_valid=1 and resp_y=8'hFD are stable throughout; no new grant until handoff.
- op=4'd12 -> resp_y=8'h00, resp_err=1; op=3 with a=4'hA -> resp_y=8'h05.
- rst=1 while in RESP -> the next cycle shows resp_valid=0 and state IDLE; a subsequent contention grants req0 first.
